vga_timing_gen: RTL and testbench

- Generates the horizontal and vertical pixel counts (vga_h, vga_v) that feed every on-screen display stage, for example the 8-bit register LED strips.
- Produces HSYNC, VSYNC and video-enable for the VGA connector.
- Delays the sync and enable outputs through a parameterised pipeline, so they line up with the registered pixel values the display stages return a fixed number of pixel periods later.
- Also provides one-clock frame-start and line-start strobes for stages that latch register values once per frame or line.

---
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, sync and video-enable generation with a
// configurable output delay, plus one-clock line/frame start strobes.
module vga_timing_gen #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit H_POL  = 1'b1,
  parameter bit V_POL  = 1'b1,
  parameter int DELAY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  output logic [10:0] vga_h,
  output logic [10:0] vga_v,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);

  // Window bounds are 12 bits wide because a sync ending at the very end of a
  // 2048-count line needs the value 2048.
  localparam logic [11:0] H_VIS_END    = 12'(H_VIS);
  localparam logic [11:0] H_SYNC_START = 12'(H_VIS + H_FP);
  localparam logic [11:0] H_SYNC_END   = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [11:0] V_VIS_END    = 12'(V_VIS);
  localparam logic [11:0] V_SYNC_START = 12'(V_VIS + V_FP);
  localparam logic [11:0] V_SYNC_END   = 12'(V_VIS + V_FP + V_SYNC);

  localparam logic [2:0] PIPE_IDLE = {~H_POL, ~V_POL, 1'b0};

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        line_q, line_d;
  logic        frame_q, frame_d;
  logic [2:0]  pipe_q [DELAY];

  logic [11:0] h_ext;
  logic [11:0] v_ext;
  logic        hs_raw;
  logic        vs_raw;
  logic        vid_raw;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d    = '0;
        line_d = 1'b1;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + 11'd1;
        end
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      line_q  <= line_d;
      frame_q <= frame_d;
    end
  end

  assign h_ext   = {1'b0, h_q};
  assign v_ext   = {1'b0, v_q};
  assign hs_raw  = ((h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END)) ? H_POL : ~H_POL;
  assign vs_raw  = ((v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END)) ? V_POL : ~V_POL;
  assign vid_raw = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);

  // Stage 0 captures the raw flags of the counts held before the edge, so the
  // last stage lags the counters by exactly DELAY pixel strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_q[i] <= PIPE_IDLE;
      end
    end else if (pix_en) begin
      pipe_q[0] <= {hs_raw, vs_raw, vid_raw};
      for (int i = 1; i < DELAY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign vga_h       = h_q;
  assign vga_v       = v_q;
  assign hsync       = pipe_q[DELAY-1][2];
  assign vsync       = pipe_q[DELAY-1][1];
  assign video_on    = pipe_q[DELAY-1][0];
  assign line_start  = line_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: three geometries compared every cycle
// against a model that derives the raster position from the count of pixel strobes.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
  } vgaObs;

  logic clk = 1'b0;
  logic rstA, rstBC;
  logic pixEnA, pixEnB, pixEnC;

  logic [10:0] hA, vA, hB, vB, hC, vC;
  logic hsA, vsA, vidA, lsA, fsA;
  logic hsB, vsB, vidB, lsB, fsB;
  logic hsC, vsC, vidC, lsC, fsC;

  int total = 0;
  int bad   = 0;

  int nA = 0, nB = 0, nC = 0;
  bit edA = 0, edB = 0, edC = 0;

  always #5 clk = ~clk;

  vga_timing_gen dutA (
    .clk(clk), .rst_n(rstA), .pix_en(pixEnA),
    .vga_h(hA), .vga_v(vA), .hsync(hsA), .vsync(vsA), .video_on(vidA),
    .line_start(lsA), .frame_start(fsA)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .DELAY(3)
  ) dutB (
    .clk(clk), .rst_n(rstBC), .pix_en(pixEnB),
    .vga_h(hB), .vga_v(vB), .hsync(hsB), .vsync(vsB), .video_on(vidB),
    .line_start(lsB), .frame_start(fsB)
  );

  // Zero back porch makes the delayed sync pulses straddle line and frame wrap.
  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(2), .H_BP(0),
    .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(0),
    .H_POL(1'b0), .V_POL(1'b0), .DELAY(2)
  ) dutC (
    .clk(clk), .rst_n(rstBC), .pix_en(pixEnC),
    .vga_h(hC), .vga_v(vC), .hsync(hsC), .vsync(vsC), .video_on(vidC),
    .line_start(lsC), .frame_start(fsC)
  );

  // The model only tracks how many pixel strobes have occurred since reset.
  always @(posedge clk or negedge rstA) begin
    if (!rstA) begin
      nA <= 0; edA <= 0;
    end else begin
      edA <= pixEnA;
      if (pixEnA) nA <= nA + 1;
    end
  end

  always @(posedge clk or negedge rstBC) begin
    if (!rstBC) begin
      nB <= 0; edB <= 0; nC <= 0; edC <= 0;
    end else begin
      edB <= pixEnB;
      edC <= pixEnC;
      if (pixEnB) nB <= nB + 1;
      if (pixEnC) nC <= nC + 1;
    end
  end

  function automatic vgaObs refModel(int n, bit ed, int hv, int hf, int hsw, int hb,
                                     int vv, int vf, int vsw, int vb,
                                     bit hp, bit vp, int dly);
    vgaObs r;
    int hT, vT, m, hm, vm;
    hT = hv + hf + hsw + hb;
    vT = vv + vf + vsw + vb;
    r.h = 11'(n % hT);
    r.v = 11'((n / hT) % vT);
    if (n >= dly) begin
      m  = n - dly;
      hm = m % hT;
      vm = (m / hT) % vT;
      r.hs  = (hm >= hv + hf && hm < hv + hf + hsw) ? hp : ~hp;
      r.vs  = (vm >= vv + vf && vm < vv + vf + vsw) ? vp : ~vp;
      r.vid = (hm < hv) && (vm < vv);
    end else begin
      r.hs  = ~hp;
      r.vs  = ~vp;
      r.vid = 1'b0;
    end
    r.ls = ed && (n % hT == 0);
    r.fs = ed && (n % (hT * vT) == 0);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic checkDut(input string tag, input vgaObs got, input vgaObs exp);
    checkOutput({tag, ".vga_h"},       32'(got.h),   32'(exp.h));
    checkOutput({tag, ".vga_v"},       32'(got.v),   32'(exp.v));
    checkOutput({tag, ".hsync"},       32'(got.hs),  32'(exp.hs));
    checkOutput({tag, ".vsync"},       32'(got.vs),  32'(exp.vs));
    checkOutput({tag, ".video_on"},    32'(got.vid), 32'(exp.vid));
    checkOutput({tag, ".line_start"},  32'(got.ls),  32'(exp.ls));
    checkOutput({tag, ".frame_start"}, 32'(got.fs),  32'(exp.fs));
  endtask

  task automatic applyStimulus(input int cyc);
    pixEnA = 1'b1;
    pixEnB = (cyc < 400) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
    pixEnC = 1'($urandom_range(0, 1));
  endtask

  task automatic checkResetA(input string tag);
    checkOutput({tag, ".vga_h"}, 32'(hA), 0);
    checkOutput({tag, ".vga_v"}, 32'(vA), 0);
    checkOutput({tag, ".hsync"}, 32'(hsA), 0);
    checkOutput({tag, ".vsync"}, 32'(vsA), 0);
    checkOutput({tag, ".video_on"}, 32'(vidA), 0);
    checkOutput({tag, ".line_start"}, 32'(lsA), 0);
    checkOutput({tag, ".frame_start"}, 32'(fsA), 0);
  endtask

  initial begin
    int holdCnt;
    bit resetDone;
    holdCnt = 0;
    resetDone = 0;
    rstA = 1'b0; rstBC = 1'b0;
    pixEnA = 1'b1; pixEnB = 1'b1; pixEnC = 1'b1;
    repeat (3) @(negedge clk);

    checkResetA("resetA");
    checkOutput("resetB.hsync", 32'(hsB), 0);
    checkOutput("resetC.hsync", 32'(hsC), 1);
    checkOutput("resetC.vsync", 32'(vsC), 1);
    checkOutput("resetC.vga_h", 32'(hC), 0);

    rstA = 1'b1; rstBC = 1'b1;
    applyStimulus(0);
    for (int cyc = 1; cyc < 2700; cyc++) begin
      @(negedge clk);
      checkDut("A", {hA, vA, hsA, vsA, vidA, lsA, fsA},
               refModel(nA, edA, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 1));
      checkDut("B", {hB, vB, hsB, vsB, vidB, lsB, fsB},
               refModel(nB, edB, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 3));
      checkDut("C", {hC, vC, hsC, vsC, vidC, lsC, fsC},
               refModel(nC, edC, 8, 2, 2, 0, 4, 1, 1, 0, 1'b0, 1'b0, 2));

      if (!resetDone) begin
        case (nA)
          800:  checkOutput("A.vidLastVisible", 32'(vidA), 1);
          801:  checkOutput("A.vidFall", 32'(vidA), 0);
          840:  checkOutput("A.hsBeforeRise", 32'(hsA), 0);
          841:  checkOutput("A.hsRise", 32'(hsA), 1);
          968:  checkOutput("A.hsBeforeFall", 32'(hsA), 1);
          969:  checkOutput("A.hsFall", 32'(hsA), 0);
          1056: begin
            checkOutput("A.wrapH", 32'(hA), 0);
            checkOutput("A.wrapV", 32'(vA), 1);
            checkOutput("A.wrapLineStart", 32'(lsA), 1);
            checkOutput("A.wrapFrameStart", 32'(fsA), 0);
          end
          1057: checkOutput("A.lineStartOneCycle", 32'(lsA), 0);
          1556: begin
            checkOutput("A.midH", 32'(hA), 500);
            checkOutput("A.midV", 32'(vA), 1);
            #2 rstA = 1'b0;
            #1 checkResetA("midReset");
            resetDone = 1;
            holdCnt = 2;
          end
          default: ;
        endcase
      end else if (holdCnt > 0) begin
        holdCnt--;
        if (holdCnt == 0) rstA = 1'b1;
      end else if (nA == 1) begin
        checkOutput("A.afterResetH", 32'(hA), 1);
        checkOutput("A.afterResetV", 32'(vA), 0);
        checkOutput("A.afterResetFrameStart", 32'(fsA), 0);
      end

      applyStimulus(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
